// File: rtl/crc_pkg.sv
// Shared CRC definitions: FSM states, CRC-8 defaults and the single-bit step function.
// The step function is the reference feedback network for both the engine and its models.
package crc_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;
   localparam int         CRC_MAXW  = 32;

   // Computed at full width; only the low w bits are meaningful.
   function automatic logic [CRC_MAXW-1:0] step(input logic [CRC_MAXW-1:0] c,
                                                input logic                d,
                                                input logic [CRC_MAXW-1:0] poly,
                                                input int                  w = 8);
      logic [CRC_MAXW-1:0] mask;
      logic [CRC_MAXW-1:0] r;
      logic                fb;
      mask = (CRC_MAXW'(1) << w) - CRC_MAXW'(1);
      fb   = c[w[4:0] - 5'd1] ^ d;
      r    = (c << 1) & mask;
      if (fb) r = r ^ (poly & mask);
      return r;
   endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational XOR feedback network: advances a W-bit CRC register by one input bit.
// Zero latency, no flow control.
module crc_step
   import crc_pkg::*;
#(
   parameter int             W    = 8,
   parameter logic [W-1:0]   POLY = W'(CRC8_POLY)
) (
   input  logic [W-1:0] c,
   input  logic         d,
   output logic [W-1:0] n
);

   assign n = W'(step(CRC_MAXW'(c), d, CRC_MAXW'(POLY), W));

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generator/checker framed by SOF/EOF; a bit accepted on an edge is in CRC after it.
// No backpressure: DVALID low simply stalls; DONE pulses one cycle after the EOF bit.
module crc_serial_engine
   import crc_pkg::*;
#(
   parameter int           W    = 8,
   parameter logic [W-1:0] POLY = W'(CRC8_POLY),
   parameter logic [W-1:0] INIT = W'(CRC8_INIT),
   parameter int           CW   = 16
) (
   input  logic          CLK,
   input  logic          R,
   input  logic          DIN,
   input  logic          DVALID,
   input  logic          SOF,
   input  logic          EOF,
   input  logic          CHKMODE,
   output logic [W-1:0]  CRC,
   output logic [CW-1:0] BITCNT,
   output logic          BUSY,
   output logic          DONE,
   output logic          ERR
);

   state_t        state_q, state_d;
   logic [W-1:0]  crc_q, crc_d;
   logic [W-1:0]  step_in, step_out;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          chk_q, chk_d;
   logic          err_q, err_d;
   logic          start;

   // A qualified SOF starts a frame from any state, which covers restart and back-to-back.
   assign start   = DVALID & SOF;
   assign step_in = start ? INIT : crc_q;

   crc_step #(
      .W    (W),
      .POLY (POLY)
   ) u_step (
      .c (step_in),
      .d (DIN),
      .n (step_out)
   );

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      chk_d   = chk_q;
      err_d   = err_q;
      if (start) begin
         crc_d   = step_out;
         cnt_d   = CW'(1);
         chk_d   = CHKMODE;
         err_d   = EOF & CHKMODE & (step_out != '0);
         state_d = EOF ? ST_DONE : ST_SHIFT;
      end else if (state_q == ST_SHIFT) begin
         if (DVALID) begin
            crc_d = step_out;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
            if (EOF) begin
               state_d = ST_DONE;
               err_d   = chk_q & (step_out != '0);
            end
         end
      end else begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         state_q <= ST_IDLE;
         crc_q   <= '0;
         cnt_q   <= '0;
         chk_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         chk_q   <= chk_d;
         err_q   <= err_d;
      end
   end

   assign CRC    = crc_q;
   assign BITCNT = cnt_q;
   assign BUSY   = (state_q == ST_SHIFT);
   assign DONE   = (state_q == ST_DONE);
   assign ERR    = err_q;

endmodule
